// File: rtl/axilite4_read_arbiter_if.sv
// Read-channel bundle between N requesting masters, the arbiter and one shared slave.
// The arbiter takes the 'slave' modport (it serves the masters and drives the slave port);
// the surrounding environment (masters plus downstream slave) takes the 'master' modport.
interface axilite4_read_arbiter_if #(
    parameter int N_MASTER = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [N_MASTER*ADDR_W-1:0] m_readAddr_addr;
    logic [N_MASTER-1:0]        m_readAddr_valid;
    logic [N_MASTER-1:0]        m_readAddr_ready;
    logic [N_MASTER*DATA_W-1:0] m_readData_data;
    logic [N_MASTER-1:0]        m_readData_valid;
    logic [N_MASTER-1:0]        m_readData_ready;
    logic [ADDR_W-1:0]          s_readAddr_addr;
    logic                       s_readAddr_valid;
    logic                       s_readAddr_ready;
    logic [DATA_W-1:0]          s_readData_data;
    logic                       s_readData_valid;
    logic                       s_readData_ready;

    modport slave (
        input  m_readAddr_addr, m_readAddr_valid, m_readData_ready,
        input  s_readAddr_ready, s_readData_data, s_readData_valid,
        output m_readAddr_ready, m_readData_data, m_readData_valid,
        output s_readAddr_addr, s_readAddr_valid, s_readData_ready
    );

    modport master (
        output m_readAddr_addr, m_readAddr_valid, m_readData_ready,
        output s_readAddr_ready, s_readData_data, s_readData_valid,
        input  m_readAddr_ready, m_readData_data, m_readData_valid,
        input  s_readAddr_addr, s_readAddr_valid, s_readData_ready
    );
endinterface

// File: rtl/axilite4_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read port among N_MASTER masters.
// One read outstanding at a time; write channels do not pass through here.
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid masters, accept winner's address
// ADDR   | present captured address to slave until it accepts
// DATA   | route slave response to the owner until the owner accepts it
module axilite4_read_arbiter #(
    parameter int N_MASTER = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axilite4_read_arbiter_if.slave bus,
    output logic [N_MASTER-1:0]  grant,
    output logic                 busy
);
    localparam int IDX_W = $clog2(N_MASTER);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [IDX_W-1:0]    r_gidx;
    logic [IDX_W-1:0]    r_last;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [N_MASTER-1:0] w_gidx_oh;
    logic                w_r_hs;

    // Round-robin search starting one past the last served master, wrapping.
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_found    = 1'b0;
        w_winner   = '0;
        w_win_addr = '0;
        idx        = '0;
        for (int k = 1; k <= N_MASTER; k++) begin
            idx = IDX_W'((int'(r_last) + k) % N_MASTER);
            if (!w_found && bus.m_readAddr_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
        for (int i = 0; i < N_MASTER; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_win_addr = bus.m_readAddr_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    // Current owner as one-hot, used for grant and response steering.
    always_comb begin
        w_gidx_oh         = '0;
        w_gidx_oh[r_gidx] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; every output is quiet outside its own state.
    always_comb begin
        w_state_nxt          = r_state;
        w_r_hs               = 1'b0;
        bus.m_readAddr_ready = '0;
        bus.m_readData_valid = '0;
        bus.s_readAddr_valid = 1'b0;
        bus.s_readAddr_addr  = '0;
        bus.s_readData_ready = 1'b0;
        grant                = '0;
        busy                 = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    bus.m_readAddr_ready[w_winner] = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                bus.s_readAddr_valid = 1'b1;
                bus.s_readAddr_addr  = r_addr_q;
                grant                = w_gidx_oh;
                busy                 = 1'b1;
                if (bus.s_readAddr_ready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                bus.m_readData_valid = bus.s_readData_valid ? w_gidx_oh : '0;
                bus.s_readData_ready = bus.m_readData_ready[r_gidx];
                grant                = w_gidx_oh;
                busy                 = 1'b1;
                w_r_hs = bus.s_readData_valid && bus.m_readData_ready[r_gidx];
                if (w_r_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read data is broadcast; only the owner's valid qualifies it.
    assign bus.m_readData_data = {N_MASTER{bus.s_readData_data}};

    // Capture winner and address on acceptance; advance the rotation on response completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_q <= '0;
            r_gidx   <= '0;
            r_last   <= IDX_W'(N_MASTER - 1);
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_addr_q <= w_win_addr;
                r_gidx   <= w_winner;
            end
            if (w_r_hs) begin
                r_last <= r_gidx;
            end
        end
    end
endmodule

// File: tb/tb_axilite4_read_arbiter.sv
// Directed bench for the read arbiter: a round-robin reference picks the expected winner,
// accepted addresses are queued and checked when they reach the slave port, and the
// response data derived from each address is checked on the owning master lane.
module tb_axilite4_read_arbiter;
    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [DW-1:0] DATA_XOR = 32'hDEAD_AEEF;

    logic clk = 1'b0;
    logic rst_n;
    logic [NM-1:0] grant;
    logic busy;

    always #5 clk = ~clk;

    axilite4_read_arbiter_if #(.N_MASTER(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

    axilite4_read_arbiter #(.N_MASTER(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .grant (grant),
        .busy  (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int req_left[NM];
    int seq[NM];
    int m_last;
    logic [AW-1:0] q_addr[$];
    int            q_m[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] lane_addr(input int m);
        return AW'(32'h1000 * (m + 1) + 32'h10 * seq[m]);
    endfunction

    task automatic drive_reqs();
        for (int m = 0; m < NM; m++) begin
            bus.m_readAddr_valid[m] = (req_left[m] > 0);
            bus.m_readAddr_addr[AW*m +: AW] = lane_addr(m);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= NM; k++) begin
            int idx;
            idx = (m_last + k) % NM;
            if (req_left[idx] > 0) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.m_readAddr_valid = '0;
        bus.m_readAddr_addr  = '0;
        bus.m_readData_ready = '1;
        bus.s_readAddr_ready = 1'b0;
        bus.s_readData_valid = 1'b0;
        bus.s_readData_data  = '0;
        m_last = NM - 1;
        q_addr.delete();
        q_m.delete();
        for (int m = 0; m < NM; m++) begin
            req_left[m] = 0;
            seq[m] = 0;
        end
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_s_arvalid", 64'(bus.s_readAddr_valid), 64'd0);
        chk("rst_s_araddr", 64'(bus.s_readAddr_addr), 64'd0);
        chk("rst_m_arready", 64'(bus.m_readAddr_ready), 64'd0);
        chk("rst_s_rready", 64'(bus.s_readData_ready), 64'd0);
        chk("rst_m_rvalid", 64'(bus.m_readData_valid), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One full read: ar_wait slave AR stall cycles, r_wait cycles before slave R valid,
    // m_wait cycles of owner backpressure, optional stray R valid while in ADDR.
    task automatic run_txn(input int ar_wait, input int r_wait, input int m_wait, input bit stray);
        int exp_m;
        int m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_m = pick();
        if (exp_m < 0) begin
            $display("FAIL bench_no_requester: observed=none expected=requester");
            $fatal(1, "no requester queued");
        end
        drive_reqs();
        #1;
        chk("idle_m_arready", 64'(bus.m_readAddr_ready), 64'(1) << exp_m);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_grant", 64'(grant), 64'd0);
        q_addr.push_back(lane_addr(exp_m));
        q_m.push_back(exp_m);
        tick();
        req_left[exp_m]--;
        seq[exp_m]++;
        drive_reqs();
        bus.s_readData_valid = stray;
        bus.s_readAddr_ready = 1'b0;
        for (int i = 0; i <= ar_wait; i++) begin
            if (i == ar_wait) bus.s_readAddr_ready = 1'b1;
            #1;
            chk("addr_s_arvalid", 64'(bus.s_readAddr_valid), 64'd1);
            chk("addr_s_araddr", 64'(bus.s_readAddr_addr), 64'(q_addr[0]));
            chk("addr_grant", 64'(grant), 64'(1) << q_m[0]);
            chk("addr_m_arready", 64'(bus.m_readAddr_ready), 64'd0);
            chk("addr_busy", 64'(busy), 64'd1);
            if (stray) begin
                chk("stray_addr_s_rready", 64'(bus.s_readData_ready), 64'd0);
                chk("stray_addr_m_rvalid", 64'(bus.m_readData_valid), 64'd0);
            end
            if (i < ar_wait) tick();
        end
        a = q_addr.pop_front();
        m = q_m.pop_front();
        d = a ^ DATA_XOR;
        tick();
        bus.s_readAddr_ready = 1'b0;
        bus.s_readData_valid = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            #1;
            chk("data_wait_m_rvalid", 64'(bus.m_readData_valid), 64'd0);
            chk("data_wait_s_arvalid", 64'(bus.s_readAddr_valid), 64'd0);
            chk("data_wait_m_arready", 64'(bus.m_readAddr_ready), 64'd0);
            tick();
        end
        bus.s_readData_valid = 1'b1;
        bus.s_readData_data  = d;
        bus.m_readData_ready[m] = 1'b0;
        for (int i = 0; i <= m_wait; i++) begin
            if (i == m_wait) bus.m_readData_ready[m] = 1'b1;
            #1;
            chk("data_m_rvalid", 64'(bus.m_readData_valid), 64'(1) << m);
            for (int j = 0; j < NM; j++) begin
                chk("data_m_rdata", 64'(bus.m_readData_data[DW*j +: DW]), 64'(d));
            end
            chk("data_s_rready", 64'(bus.s_readData_ready), (i == m_wait) ? 64'd1 : 64'd0);
            chk("data_m_arready", 64'(bus.m_readAddr_ready), 64'd0);
            chk("data_grant", 64'(grant), 64'(1) << m);
            if (i < m_wait) tick();
        end
        tick();
        bus.s_readData_valid = 1'b0;
        m_last = m;
        #1;
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_grant", 64'(grant), 64'd0);
    endtask

    initial begin
        do_reset();

        // single read from m0: addr 0x1000, data 0xDEADBEEF
        req_left[0] = 1;
        run_txn(0, 0, 0, 0);

        // lone requester granted back-to-back
        req_left[0] = 2;
        run_txn(0, 0, 0, 0);
        run_txn(0, 0, 0, 0);

        // stray response in IDLE
        bus.s_readData_valid = 1'b1;
        #1;
        chk("stray_idle_s_rready", 64'(bus.s_readData_ready), 64'd0);
        chk("stray_idle_m_rvalid", 64'(bus.m_readData_valid), 64'd0);
        tick();
        bus.s_readData_valid = 1'b0;

        // contention from reset: grant 01,10,01,10,...
        do_reset();
        req_left[0] = 4;
        req_left[1] = 4;
        repeat (8) run_txn(0, 0, 0, 0);

        // slave backpressure with stray R valid during ADDR
        req_left[0] = 1;
        run_txn(3, 2, 0, 1);

        // owner backpressure on m1
        req_left[1] = 1;
        run_txn(0, 0, 4, 0);

        // reset mid-DATA, then m0 has priority again
        do_reset();
        req_left[1] = 1;
        drive_reqs();
        #1;
        chk("rstdata_m_arready", 64'(bus.m_readAddr_ready), 64'b10);
        tick();
        req_left[1] = 0;
        seq[1]++;
        drive_reqs();
        bus.s_readAddr_ready = 1'b1;
        tick();
        bus.s_readAddr_ready = 1'b0;
        bus.s_readData_valid = 1'b1;
        bus.s_readData_data  = 32'h1234_5678;
        #1;
        chk("rstdata_pre_busy", 64'(busy), 64'd1);
        chk("rstdata_pre_grant", 64'(grant), 64'b10);
        chk("rstdata_pre_s_rready", 64'(bus.s_readData_ready), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstdata_busy", 64'(busy), 64'd0);
        chk("rstdata_grant", 64'(grant), 64'd0);
        chk("rstdata_s_rready", 64'(bus.s_readData_ready), 64'd0);
        chk("rstdata_m_rvalid", 64'(bus.m_readData_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.s_readData_valid = 1'b0;
        m_last = NM - 1;
        req_left[0] = 1;
        req_left[1] = 1;
        run_txn(0, 0, 0, 0);
        run_txn(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
